// File: rtl/voter_tally_if.sv
// Ballot bus between the voter input logic and the tally block.
// The slave side is the tally; the master side drives ballots and consumes the verdict.
interface voter_tally_if #(
    parameter int N_VOTERS = 4
);
    localparam int CW = $clog2(N_VOTERS + 1);

    logic                start;
    logic                close;
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_yes;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [CW-1:0]       yes_cnt;
    logic [CW-1:0]       no_cnt;
    logic                done;
    logic                pass;
    logic                tie;
    logic                timed_out;
    logic                dup_err;

    modport master (
        output start, close, vote_valid, vote_yes,
        input  busy, voted, yes_cnt, no_cnt, done, pass, tie, timed_out, dup_err
    );

    modport slave (
        input  start, close, vote_valid, vote_yes,
        output busy, voted, yes_cnt, no_cnt, done, pass, tie, timed_out, dup_err
    );
endinterface

// File: rtl/voter_tally.sv
// Timed ballot over N_VOTERS lines: one vote per voter, closes on all-voted,
// explicit close or timeout, and registers tallies plus a pass/tie verdict.
module voter_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic open,
    input  logic vote_valid,
    input  logic vote_yes,
    output logic voted,
    output logic voted_nxt,
    output logic new_yes,
    output logic new_no,
    output logic dup
);
    logic accept;

    assign accept    = open && vote_valid && !voted;
    assign new_yes   = accept && vote_yes;
    assign new_no    = accept && !vote_yes;
    assign dup       = open && vote_valid && voted;
    assign voted_nxt = voted || accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      voted <= 1'b0;
        else if (clear)  voted <= 1'b0;
        else if (accept) voted <= 1'b1;
    end
endmodule

module voter_tally #(
    parameter  int N_VOTERS = 4,
    parameter  int MODE     = 0,
    parameter  int TIMEOUT  = 16,
    localparam int CW       = $clog2(N_VOTERS + 1)
) (
    input logic           clk,
    input logic           rst_n,
    voter_tally_if.slave  bus
);
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_RESULT} state_t;

    state_t state_q, state_d;
    logic   clear, close_now, open;
    logic   all_voted, timeout_hit;
    logic   pass_d, tie_d;

    logic [N_VOTERS-1:0] voted_q, voted_nxt, new_yes, new_no, dup;
    logic [CW-1:0]       y_add, n_add, y_fin, n_fin;
    logic [TW-1:0]       timer;

    assign open = (state_q == S_OPEN);

    for (genvar i = 0; i < N_VOTERS; i++) begin : g_lane
        voter_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .open       (open),
            .vote_valid (bus.vote_valid[i]),
            .vote_yes   (bus.vote_yes[i]),
            .voted      (voted_q[i]),
            .voted_nxt  (voted_nxt[i]),
            .new_yes    (new_yes[i]),
            .new_no     (new_no[i]),
            .dup        (dup[i])
        );
    end

    // Popcounts of this cycle's accepted votes; the final tally includes them.
    always_comb begin
        y_add = '0;
        n_add = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            y_add = y_add + CW'(new_yes[i]);
            n_add = n_add + CW'(new_no[i]);
        end
    end

    assign y_fin       = bus.yes_cnt + y_add;
    assign n_fin       = bus.no_cnt + n_add;
    assign all_voted   = &voted_nxt;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TMAX));

    if (MODE == 0) begin : g_simple
        assign pass_d = {1'b0, y_fin} > {1'b0, n_fin};
        assign tie_d  = (y_fin == n_fin);
    end else if (MODE == 1) begin : g_absolute
        assign pass_d = {y_fin, 1'b0} > (CW+1)'(N_VOTERS);
        assign tie_d  = 1'b0;
    end else begin : g_unanimous
        assign pass_d = ({1'b0, y_fin} == (CW+1)'(N_VOTERS));
        assign tie_d  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        close_now = 1'b0;
        case (state_q)
            S_IDLE, S_RESULT: begin
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                if (all_voted || bus.close || timeout_hit) begin
                    close_now = 1'b1;
                    state_d   = S_RESULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     timer <= '0;
        else if (clear) timer <= '0;
        else if (open)  timer <= timer + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.yes_cnt   <= '0;
            bus.no_cnt    <= '0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.tie       <= 1'b0;
            bus.timed_out <= 1'b0;
            bus.dup_err   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (clear) begin
                bus.yes_cnt   <= '0;
                bus.no_cnt    <= '0;
                bus.pass      <= 1'b0;
                bus.tie       <= 1'b0;
                bus.timed_out <= 1'b0;
                bus.dup_err   <= 1'b0;
            end else if (open) begin
                bus.yes_cnt <= y_fin;
                bus.no_cnt  <= n_fin;
                if (|dup) bus.dup_err <= 1'b1;
                if (close_now) begin
                    bus.done      <= 1'b1;
                    bus.pass      <= pass_d;
                    bus.tie       <= tie_d;
                    // Timer only gets the credit when nothing else closed the ballot.
                    bus.timed_out <= timeout_hit && !all_voted && !bus.close;
                end
            end
        end
    end

    assign bus.busy  = open;
    assign bus.voted = voted_q;
endmodule
